// File: rtl/adc_pkg.sv
// Shared constants and state type for the serial ADC link responder.
package adc_pkg;

    localparam int ADC_DATA_W     = 12;
    localparam int ADC_NUM_CH     = 8;
    localparam int ADC_ADDR_W     = 3;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_ZEROS = 4;

    // Rising-edge counts (before increment) that carry ADD2, ADD1, ADD0 on DIN.
    localparam int ADDR_FIRST_BIT = 2;
    localparam int ADDR_LAST_BIT  = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } adc_state_e;

endpackage

// File: rtl/adc_sync_edge.sv
// Two-flop synchronizer with an extra history flop for rise/fall detection.
module adc_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Chip-side responder for the 8-channel 12-bit serial ADC link (CS/SCLK/DIN/DOUT).
// Define ADC_RESP_TRISTATE_EN to float adc_dout while the responder is idle.
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int NUM_CH     = ADC_NUM_CH,
    parameter int ADDR_W     = ADC_ADDR_W,
    parameter int FRAME_BITS = ADC_FRAME_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adc_cs,
    input  logic                     adc_sclk,
    input  logic                     adc_din,
    output logic                     adc_dout,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0]        conv_ch,
    output logic                     sample_strobe,
    output logic                     frame_done,
    output logic                     short_frame
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int LEAD  = FRAME_BITS - DATA_W;

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic din_meta_q, din_sync_q;

    // CS flops clear to "selected" so a CS already low at reset release never
    // looks like a fresh falling edge.
    adc_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_cs),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    adc_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    adc_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]     addr_sr_q, addr_sr_d;
    logic [ADDR_W-1:0]     next_ch_q, next_ch_d;
    logic [ADDR_W-1:0]     conv_ch_q, conv_ch_d;
    logic                  edge_seen_q, edge_seen_d;
    logic                  adc_dout_q, adc_dout_d;
    logic                  sample_strobe_q, sample_strobe_d;
    logic                  frame_done_q, frame_done_d;
    logic                  short_frame_q, short_frame_d;

    logic                  load;
    logic [ADDR_W-1:0]     load_ch;
    logic [ADDR_W-1:0]     addr_dec;
    logic [FRAME_BITS-1:0] load_word;

    assign addr_dec  = (int'(addr_sr_q) >= NUM_CH) ? '0 : addr_sr_q;
    assign load_word = {{LEAD{1'b0}}, sample_data[int'(load_ch)*DATA_W +: DATA_W]};

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        addr_sr_d       = addr_sr_q;
        next_ch_d       = next_ch_q;
        conv_ch_d       = conv_ch_q;
        edge_seen_d     = edge_seen_q;
        adc_dout_d      = adc_dout_q;
        sample_strobe_d = 1'b0;
        frame_done_d    = 1'b0;
        short_frame_d   = 1'b0;
        load            = 1'b0;
        load_ch         = next_ch_q;

        case (state_q)
            IDLE: begin
                adc_dout_d = 1'b0;
                if (cs_fall) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // CS release takes priority over any SCLK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d       = IDLE;
                    adc_dout_d    = 1'b0;
                    short_frame_d = (bit_cnt_q != '0) || edge_seen_q;
                end else if (sclk_fall) begin
                    shift_d     = shift_q << 1;
                    adc_dout_d  = shift_q[FRAME_BITS-2];
                    edge_seen_d = 1'b1;
                end else if (sclk_rise) begin
                    edge_seen_d = 1'b1;
                    if (bit_cnt_q >= CNT_W'(ADDR_FIRST_BIT) && bit_cnt_q <= CNT_W'(ADDR_LAST_BIT)) begin
                        addr_sr_d = {addr_sr_q[ADDR_W-2:0], din_sync_q};
                    end
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        frame_done_d = 1'b1;
                        next_ch_d    = addr_dec;
                        load         = 1'b1;
                        load_ch      = addr_dec;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d         = load_word;
            adc_dout_d      = load_word[FRAME_BITS-1];
            conv_ch_d       = load_ch;
            sample_strobe_d = 1'b1;
            bit_cnt_d       = '0;
            addr_sr_d       = '0;
            edge_seen_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            addr_sr_q       <= '0;
            next_ch_q       <= '0;
            conv_ch_q       <= '0;
            edge_seen_q     <= 1'b0;
            adc_dout_q      <= 1'b0;
            sample_strobe_q <= 1'b0;
            frame_done_q    <= 1'b0;
            short_frame_q   <= 1'b0;
            din_meta_q      <= 1'b0;
            din_sync_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            addr_sr_q       <= addr_sr_d;
            next_ch_q       <= next_ch_d;
            conv_ch_q       <= conv_ch_d;
            edge_seen_q     <= edge_seen_d;
            adc_dout_q      <= adc_dout_d;
            sample_strobe_q <= sample_strobe_d;
            frame_done_q    <= frame_done_d;
            short_frame_q   <= short_frame_d;
            din_meta_q      <= adc_din;
            din_sync_q      <= din_meta_q;
        end
    end

`ifdef ADC_RESP_TRISTATE_EN
    assign adc_dout = (state_q == SHIFT) ? adc_dout_q : 1'bz;
`else
    assign adc_dout = adc_dout_q;
`endif
    assign conv_ch       = conv_ch_q;
    assign sample_strobe = sample_strobe_q;
    assign frame_done    = frame_done_q;
    assign short_frame   = short_frame_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed frame table, hand sequences, randomized frames vs a frame-level model.
module tb_adc_spi_responder;
    import adc_pkg::*;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic adc_cs, adc_sclk, adc_din, adc_dout;
    logic [ADC_NUM_CH*ADC_DATA_W-1:0] sample_data;
    logic [ADC_ADDR_W-1:0] conv_ch;
    logic sample_strobe, frame_done, short_frame;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0, n_done = 0, n_short = 0;

    logic [11:0] ch_val [8];

    typedef struct {
        bit          cont;
        logic [2:0]  addr;
        logic [2:0]  exp_ch;
        logic [11:0] exp_data;
    } vec_t;
    vec_t vec [7];

    int          m_next;
    logic [2:0]  m_ch;
    logic [11:0] m_word;
    int          m_loads;

    always #5 clk = ~clk;

    adc_spi_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .adc_cs        (adc_cs),
        .adc_sclk      (adc_sclk),
        .adc_din       (adc_din),
        .adc_dout      (adc_dout),
        .sample_data   (sample_data),
        .conv_ch       (conv_ch),
        .sample_strobe (sample_strobe),
        .frame_done    (frame_done),
        .short_frame   (short_frame)
    );

    always @(negedge clk) begin
        if (sample_strobe === 1'b1) n_strobe++;
        if (frame_done === 1'b1)    n_done++;
        if (short_frame === 1'b1)   n_short++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_samples();
        for (int k = 0; k < 8; k++) sample_data[k*ADC_DATA_W +: ADC_DATA_W] = ch_val[k];
    endtask

    task automatic randomize_samples();
        for (int k = 0; k < 8; k++) ch_val[k] = 12'($urandom_range(0, 4095));
        drive_samples();
    endtask

    task automatic cs_low();
        adc_cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        adc_cs = 1'b1;
        wait_clk(HALF);
    endtask

    // dout is read while SCLK is still high, just before each falling edge.
    task automatic run_frame(input logic [2:0] addr, input int n_rises, input bit mutate,
                             output logic [15:0] bits);
        bits = '0;
        for (int k = 1; k <= n_rises; k++) begin
            bits[16-k] = adc_dout;
            adc_sclk = 1'b0;
            case (k)
                3:       adc_din = addr[2];
                4:       adc_din = addr[1];
                5:       adc_din = addr[0];
                default: adc_din = 1'($urandom_range(0, 1));
            endcase
            wait_clk(HALF);
            adc_sclk = 1'b1;
            wait_clk(HALF);
            if (mutate && k == 8) randomize_samples();
        end
    endtask

    task automatic model_load();
        m_ch   = 3'(m_next);
        m_word = ch_val[m_next];
        m_loads++;
    endtask

    initial begin
        #5_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [15:0] bits;
        logic [2:0]  ch_start;
        int d0, s0, sh0, s_base;
        bit cs_is_low, cont, full;
        int n;
        logic [2:0] addr;

        ch_val = '{12'hA5C, 12'h800, 12'h002, 12'h123, 12'h456, 12'h3F1, 12'h789, 12'hFFF};
        drive_samples();
        vec[0] = '{1'b0, 3'd0, 3'd0, 12'hA5C};
        vec[1] = '{1'b0, 3'd5, 3'd0, 12'hA5C};
        vec[2] = '{1'b0, 3'd2, 3'd5, 12'h3F1};
        vec[3] = '{1'b1, 3'd7, 3'd2, 12'h002};
        vec[4] = '{1'b1, 3'd1, 3'd7, 12'hFFF};
        vec[5] = '{1'b0, 3'd3, 3'd1, 12'h800};
        vec[6] = '{1'b0, 3'd4, 3'd3, 12'h123};

        rst_n = 1'b0; adc_cs = 1'b1; adc_sclk = 1'b1; adc_din = 1'b0;
        wait_clk(5);
        check("rst_dout", 32'(adc_dout), 32'd0);
        check("rst_conv_ch", 32'(conv_ch), 32'd0);
        check("rst_pulses", 32'({sample_strobe, frame_done, short_frame}), 32'd0);
        rst_n = 1'b1;
        wait_clk(10);
        check("idle_no_strobe", 32'(n_strobe), 32'd0);
        check("idle_dout", 32'(adc_dout), 32'd0);

        s_base = 0;
        for (int i = 0; i < 7; i++) begin
            if (!vec[i].cont) begin
                if (i > 0) begin
                    cs_high();
                    check("tbl_idle_dout", 32'(adc_dout), 32'd0);
                end
                if (i == 2) s_base = n_strobe;
                cs_low();
            end
            check("tbl_conv_ch", 32'(conv_ch), 32'(vec[i].exp_ch));
            d0 = n_done;
            run_frame(vec[i].addr, 16, 1'b0, bits);
            check("tbl_dout_bits", 32'(bits), 32'({4'h0, vec[i].exp_data}));
            check("tbl_frame_done", 32'(n_done - d0), 32'd1);
            if (i == 3) check("cont_strobes", 32'(n_strobe - s_base), 32'd3);
        end

        // short frame: address 6 sent but frame cut after 7 rising edges
        cs_high();
        cs_low();
        check("short_conv_ch", 32'(conv_ch), 32'd4);
        d0 = n_done; sh0 = n_short;
        run_frame(3'd6, 7, 1'b0, bits);
        cs_high();
        check("short_pulse", 32'(n_short - sh0), 32'd1);
        check("short_no_done", 32'(n_done - d0), 32'd0);
        check("short_idle_dout", 32'(adc_dout), 32'd0);
        cs_low();
        check("after_short_ch", 32'(conv_ch), 32'd4);
        run_frame(3'd3, 16, 1'b0, bits);
        check("after_short_bits", 32'(bits), 32'h0456);

        // reset in the middle of a frame shifting channel 3
        cs_high();
        cs_low();
        check("prereset_ch", 32'(conv_ch), 32'd3);
        run_frame(3'd7, 9, 1'b0, bits);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", 32'(adc_dout), 32'd0);
        check("midrst_conv_ch", 32'(conv_ch), 32'd0);
        wait_clk(3);
        rst_n = 1'b1;
        s0 = n_strobe;
        wait_clk(10);
        check("midrst_no_restart", 32'(n_strobe - s0), 32'd0);
        cs_high();
        cs_low();
        check("postrst_ch", 32'(conv_ch), 32'd0);
        run_frame(3'd2, 16, 1'b0, bits);
        check("postrst_bits", 32'(bits), 32'h0A5C);

        // randomized frames against the frame-level model
        m_next = 2;
        m_loads = 0;
        cs_is_low = 1'b1;
        full = 1'b1;
        cs_high();
        cs_is_low = 1'b0;
        s_base = n_strobe;
        for (int f = 0; f < 30; f++) begin
            cont = cs_is_low && full && ($urandom_range(0, 2) != 0);
            if (!cont) begin
                if (cs_is_low) begin
                    cs_high();
                    check("rnd_idle_dout", 32'(adc_dout), 32'd0);
                end
                randomize_samples();
                wait_clk(2);
                cs_low();
                cs_is_low = 1'b1;
                model_load();
            end
            full = ($urandom_range(0, 3) != 0);
            n    = full ? 16 : $urandom_range(1, 15);
            addr = 3'($urandom_range(0, 7));
            ch_start = conv_ch;
            check("rnd_conv_ch", 32'(ch_start), 32'(m_ch));
            d0 = n_done; sh0 = n_short;
            run_frame(addr, n, 1'b1, bits);
            if (full) begin
                check("rnd_bits", 32'(bits), 32'({4'h0, m_word}));
                check("rnd_done", 32'(n_done - d0), 32'd1);
                m_next = (int'(addr) < ADC_NUM_CH) ? int'(addr) : 0;
                model_load();
            end else begin
                check("rnd_short_bits", 32'(bits >> (16 - n)), 32'({4'h0, m_word} >> (16 - n)));
                cs_high();
                cs_is_low = 1'b0;
                check("rnd_short_pulse", 32'(n_short - sh0), 32'd1);
                check("rnd_short_no_done", 32'(n_done - d0), 32'd0);
            end
        end
        wait_clk(4);
        check("rnd_strobe_total", 32'(n_strobe - s_base), 32'(m_loads));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
